// File: rtl/param_stack_pkg.sv
// param_stack_pkg: shared op encoding ({pop,push}) and default sizing for param_stack.
package param_stack_pkg;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 256;
endpackage

// File: rtl/stack_ram.sv
// stack_ram: DEPTH x DATA_W storage, synchronous write, asynchronous read (distributed-RAM friendly).
module stack_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with replace-top on push+pop and overflow/underflow reporting.
// Define PARAM_STACK_STICKY_ERR_EN for sticky ovf/unf cleared by err_clr; otherwise they are one-cycle pulses.
module param_stack
  import param_stack_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] top_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf,
  input  logic              err_clr
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0]        op;
  logic [CNT_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  count_nxt;
  logic [CNT_W-1:0]  waddr;
  logic              we;
  logic              grow;
  logic              shrink;
  logic              ovf_ev;
  logic              unf_ev;
  logic [DATA_W-1:0] rd_data;
  assign op       = {pop, push};
  assign empty    = count == '0;
  assign full     = count == CNT_W'(DEPTH);
  assign top_ptr  = count - 1'b1;
  assign top_data = empty ? '0 : rd_data;
  always_comb begin
    grow      = (op == OP_PUSH && !full) || (op == OP_REPL && empty);
    shrink    = op == OP_POP && !empty;
    we        = (op == OP_PUSH && !full) || op == OP_REPL;
    waddr     = (op == OP_REPL && !empty) ? top_ptr : count;
    count_nxt = grow ? count + 1'b1 : shrink ? count - 1'b1 : count;
    ovf_ev    = op == OP_PUSH && full;
    unf_ev    = pop && empty;
  end
  stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr[AW-1:0]),
    .wdata (din),
    .raddr (top_ptr[AW-1:0]),
    .rdata (rd_data)
  );
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      count <= '0;
      dout  <= '0;
    end else begin
      count <= count_nxt;
      if (pop && !empty) dout <= rd_data;
    end
`ifdef PARAM_STACK_STICKY_ERR_EN
  // a new event in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_ev || (ovf && !err_clr);
      unf <= unf_ev || (unf && !err_clr);
    end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_ev;
      unf <= unf_ev;
    end
`endif
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: randomized + directed check of param_stack against a queue-based LIFO model.
module tb_param_stack;
  logic        clk = 1'b0;
  logic        clr, push, pop, err_clr;
  logic [15:0] din, dout, top_data;
  logic [2:0]  count;
  logic        empty, full, ovf, unf;
  logic        push5;
  logic [15:0] din5, dout5, top5;
  logic [2:0]  count5;
  logic        empty5, full5, ovf5, unf5;
  int errs = 0, checks = 0;
  logic [15:0] q[$];
  logic [15:0] dout_m;
  logic        ovf_m, unf_m;

  always #5 clk = ~clk;

  param_stack #(.DATA_W(16), .DEPTH(4)) u_dut (
    .clk(clk), .clr(clr), .push(push), .pop(pop), .din(din), .dout(dout),
    .top_data(top_data), .count(count), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf), .err_clr(err_clr)
  );

  param_stack #(.DATA_W(16), .DEPTH(5)) u_dut5 (
    .clk(clk), .clr(clr), .push(push5), .pop(1'b0), .din(din5), .dout(dout5),
    .top_data(top5), .count(count5), .empty(empty5), .full(full5),
    .ovf(ovf5), .unf(unf5), .err_clr(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    dout_m = '0;
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
  endtask

  task automatic model_step(input logic pu, input logic po, input logic [15:0] d, input logic ec);
    bit f, e, oe, ue;
    f  = q.size() == 4;
    e  = q.size() == 0;
    oe = pu && !po && f;
    ue = po && e;
    if (pu && po && !e) begin
      dout_m = q[q.size()-1];
      q[q.size()-1] = d;
    end else if (pu && !f) q.push_back(d);
    else if (po && !e) dout_m = q.pop_back();
`ifdef PARAM_STACK_STICKY_ERR_EN
    ovf_m = oe || (ovf_m && !ec);
    unf_m = ue || (unf_m && !ec);
`else
    ovf_m = oe;
    unf_m = ue;
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(q.size() == 4));
    chk({tag, ".top"},   32'(top_data), 32'(q.size() ? q[q.size()-1] : 16'h0));
    chk({tag, ".dout"},  32'(dout), 32'(dout_m));
    chk({tag, ".ovf"},   32'(ovf), 32'(ovf_m));
    chk({tag, ".unf"},   32'(unf), 32'(unf_m));
  endtask

  task automatic cycle(input string tag, input logic pu, input logic po, input logic [15:0] d, input logic ec = 1'b0);
    push = pu; pop = po; din = d; err_clr = ec;
    @(posedge clk);
    model_step(pu, po, d, ec);
    #1;
    check_all(tag);
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; push = 0; pop = 0; err_clr = 0; din = '0; push5 = 0; din5 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    clr = 1'b0;
    // basic LIFO order
    cycle("push1", 1, 0, 16'h0011);
    cycle("push2", 1, 0, 16'h0022);
    cycle("push3", 1, 0, 16'h0033);
    chk("top3", 32'(top_data), 32'h33);
    chk("cnt3", 32'(count), 32'd3);
    cycle("pop1", 0, 1, '0); chk("pop1.val", 32'(dout), 32'h33);
    cycle("pop2", 0, 1, '0); chk("pop2.val", 32'(dout), 32'h22);
    cycle("pop3", 0, 1, '0); chk("pop3.val", 32'(dout), 32'h11);
    chk("empty3", 32'(empty), 32'd1);
    // overflow
    for (int i = 0; i < 4; i++) cycle("fill", 1, 0, 16'hA0 + 16'(i));
    cycle("ovf", 1, 0, 16'hBEEF);
    chk("ovf.flag", 32'(ovf), 32'd1);
    chk("ovf.full", 32'(full), 32'd1);
    cycle("ovf.idle", 0, 0, '0);
`ifdef PARAM_STACK_STICKY_ERR_EN
    chk("ovf.sticky", 32'(ovf), 32'd1);
    cycle("ovf.errclr", 0, 0, '0, 1'b1);
    chk("ovf.cleared", 32'(ovf), 32'd0);
`else
    chk("ovf.pulse", 32'(ovf), 32'd0);
`endif
    cycle("ovf.pop", 0, 1, '0);
    chk("ovf.popval", 32'(dout), 32'hA3);
    for (int i = 0; i < 3; i++) cycle("drain", 0, 1, '0);
    // underflow and push+pop on empty
    cycle("unf", 0, 1, '0);
    chk("unf.flag", 32'(unf), 32'd1);
    chk("unf.dout", 32'(dout), 32'hA0);
    cycle("unf.repl", 1, 1, 16'h1234);
    chk("unf.repl.top", 32'(top_data), 32'h1234);
    chk("unf.repl.unf", 32'(unf), 32'd1);
    cycle("drain1", 0, 1, '0, 1'b1);
    // replace-top
    cycle("rp.push1", 1, 0, 16'h0001);
    cycle("rp.push2", 1, 0, 16'h0002);
    cycle("repl", 1, 1, 16'h00AA);
    chk("repl.dout", 32'(dout), 32'h2);
    chk("repl.top", 32'(top_data), 32'hAA);
    chk("repl.cnt", 32'(count), 32'd2);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom_range(0, 7) == 0));
    // asynchronous clear mid-burst
    cycle("burst", 1, 0, 16'h0B01);
    push = 1'b1; din = 16'h0B02;
    @(posedge clk);
    model_step(1, 0, 16'h0B02, 0);
    #3 clr = 1'b1;
    #1;
    model_reset();
    check_all("aclr");
    @(posedge clk);
    #1;
    check_all("aclr.hold");
    clr = 1'b0; push = 1'b0;
    cycle("aclr.idle", 0, 0, '0);
    // DEPTH=5 instance
    for (int i = 0; i < 6; i++) begin
      push5 = 1'b1; din5 = 16'(i + 1);
      @(posedge clk);
      #1;
      chk("d5.full", 32'(full5), 32'(i >= 4));
      chk("d5.ovf", 32'(ovf5), 32'(i == 5));
    end
    push5 = 1'b0;
    chk("d5.cnt", 32'(count5), 32'd5);
    chk("d5.top", 32'(top5), 32'd5);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
